// File: rtl/audio_peak_meter_if.sv
// audio_peak_meter_if: sample-in / meter-out bundle for audio_peak_meter.
//   rx_valid, rx_left, rx_right   : frame strobe and signed 24-bit samples from the I2S receiver
//   meter_valid                   : one-cycle pulse when meter levels update
//   meter_left, meter_right       : decimated peak levels (OUT_BITS wide)
//   clip_left, clip_right         : clip indicators
// master drives samples (receiver side), slave is the meter.
interface audio_peak_meter_if #(
  parameter int unsigned OUT_BITS = 16
);
  logic                rx_valid;
  logic [23:0]         rx_left;
  logic [23:0]         rx_right;
  logic                meter_valid;
  logic [OUT_BITS-1:0] meter_left;
  logic [OUT_BITS-1:0] meter_right;
  logic                clip_left;
  logic                clip_right;

  modport master (
    output rx_valid, rx_left, rx_right,
    input  meter_valid, meter_left, meter_right, clip_left, clip_right
  );

  modport slave (
    input  rx_valid, rx_left, rx_right,
    output meter_valid, meter_left, meter_right, clip_left, clip_right
  );
endinterface

// File: rtl/audio_peak_meter.sv
// audio_peak_meter: stereo peak meter for 24-bit I2S frames.
// Rectifies each sample, tracks peak with instant attack, hold and release, and emits
// decimated meter levels every UPDATE_DIV frames.
//   mclk      : audio clock, all logic on rising edge
//   mclk_rst  : synchronous active-high reset
//   bus       : audio_peak_meter_if.slave (rx_* in, meter_* / clip_* out)
// Optional feature: define AUDIO_PEAK_METER_CLIP_EN to enable per-channel clip indicators;
// otherwise clip_left/clip_right are tied to 0.
// Pipeline: stage 1 rectify (T+1), stage 2 peak/hold/frame count (T+2), stage 3 outputs (T+3).
module audio_peak_meter #(
  parameter int unsigned HOLD_FRAMES = 2400,
  parameter int unsigned DECAY_SHIFT = 10,
  parameter int unsigned UPDATE_DIV  = 48,
  parameter int unsigned OUT_BITS    = 16
) (
  input logic                mclk,
  input logic                mclk_rst,
  audio_peak_meter_if.slave  bus
);

  localparam logic [15:0] HoldInit = 16'(HOLD_FRAMES);
  localparam logic [15:0] UpdLast  = 16'(UPDATE_DIV - 1);

  // |s| as 23-bit unsigned; the most negative code saturates to full scale.
  function automatic logic [22:0] rectify(input logic [23:0] s);
    logic [23:0] neg;
    neg = -s;
    if (!s[23])              return s[22:0];
    else if (s == 24'h800000) return 23'h7FFFFF;
    else                     return neg[22:0];
  endfunction

  // Returns {hold_next, peak_next}. step <= peak, so the release never underflows.
  function automatic logic [38:0] track(input logic [22:0] mag, input logic [22:0] peak,
                                        input logic [15:0] hold);
    logic [22:0] step;
    step = peak >> DECAY_SHIFT;
    if (step == 23'd0) step = 23'd1;
    if (mag >= peak)        return {HoldInit, mag};
    else if (hold != 16'd0) return {hold - 16'd1, peak};
    else if (peak != 23'd0) return {hold, peak - step};
    else                    return {hold, peak};
  endfunction

  logic [22:0]         mag_l_q, mag_l_d, mag_r_q, mag_r_d;
  logic                mag_valid_q, mag_valid_d;
  logic [22:0]         peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [15:0]         hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [15:0]         frame_q, frame_d;
  logic                upd_q, upd_d;
  logic                meter_valid_q, meter_valid_d;
  logic [OUT_BITS-1:0] meter_left_q, meter_left_d, meter_right_q, meter_right_d;

  always_comb begin
    // Stage 1
    mag_valid_d = bus.rx_valid;
    mag_l_d     = bus.rx_valid ? rectify(bus.rx_left)  : mag_l_q;
    mag_r_d     = bus.rx_valid ? rectify(bus.rx_right) : mag_r_q;

    // Stage 2
    {hold_l_d, peak_l_d} = {hold_l_q, peak_l_q};
    {hold_r_d, peak_r_d} = {hold_r_q, peak_r_q};
    frame_d              = frame_q;
    upd_d                = 1'b0;
    if (mag_valid_q) begin
      {hold_l_d, peak_l_d} = track(mag_l_q, peak_l_q, hold_l_q);
      {hold_r_d, peak_r_d} = track(mag_r_q, peak_r_q, hold_r_q);
      if (frame_q == UpdLast) begin
        frame_d = 16'd0;
        upd_d   = 1'b1;
      end else begin
        frame_d = frame_q + 16'd1;
      end
    end

    // Stage 3: peak_*_q already holds the post-update value when upd_q is set.
    meter_valid_d = upd_q;
    meter_left_d  = upd_q ? peak_l_q[22 -: OUT_BITS] : meter_left_q;
    meter_right_d = upd_q ? peak_r_q[22 -: OUT_BITS] : meter_right_q;
  end

  always_ff @(posedge mclk) begin
    if (mclk_rst) begin
      mag_l_q       <= '0;
      mag_r_q       <= '0;
      mag_valid_q   <= 1'b0;
      peak_l_q      <= '0;
      peak_r_q      <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_q       <= '0;
      upd_q         <= 1'b0;
      meter_valid_q <= 1'b0;
      meter_left_q  <= '0;
      meter_right_q <= '0;
    end else begin
      mag_l_q       <= mag_l_d;
      mag_r_q       <= mag_r_d;
      mag_valid_q   <= mag_valid_d;
      peak_l_q      <= peak_l_d;
      peak_r_q      <= peak_r_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_q       <= frame_d;
      upd_q         <= upd_d;
      meter_valid_q <= meter_valid_d;
      meter_left_q  <= meter_left_d;
      meter_right_q <= meter_right_d;
    end
  end

  assign bus.meter_valid = meter_valid_q;
  assign bus.meter_left  = meter_left_q;
  assign bus.meter_right = meter_right_q;

`ifdef AUDIO_PEAK_METER_CLIP_EN
  localparam logic [22:0] ClipThresh = 23'h7FFF00;
  localparam logic [15:0] ClipInit   = 16'd24000;

  logic [15:0] clip_cnt_l_q, clip_cnt_l_d, clip_cnt_r_q, clip_cnt_r_d;
  logic        st2_valid_q, st2_valid_d;
  logic        clip_left_q, clip_left_d, clip_right_q, clip_right_d;

  always_comb begin
    clip_cnt_l_d = clip_cnt_l_q;
    clip_cnt_r_d = clip_cnt_r_q;
    st2_valid_d  = mag_valid_q;
    if (mag_valid_q) begin
      if (mag_l_q >= ClipThresh)      clip_cnt_l_d = ClipInit;
      else if (clip_cnt_l_q != 16'd0) clip_cnt_l_d = clip_cnt_l_q - 16'd1;
      if (mag_r_q >= ClipThresh)      clip_cnt_r_d = ClipInit;
      else if (clip_cnt_r_q != 16'd0) clip_cnt_r_d = clip_cnt_r_q - 16'd1;
    end
    // Clip flags refresh every frame, not just on meter updates.
    clip_left_d  = st2_valid_q ? (clip_cnt_l_q != 16'd0) : clip_left_q;
    clip_right_d = st2_valid_q ? (clip_cnt_r_q != 16'd0) : clip_right_q;
  end

  always_ff @(posedge mclk) begin
    if (mclk_rst) begin
      clip_cnt_l_q <= '0;
      clip_cnt_r_q <= '0;
      st2_valid_q  <= 1'b0;
      clip_left_q  <= 1'b0;
      clip_right_q <= 1'b0;
    end else begin
      clip_cnt_l_q <= clip_cnt_l_d;
      clip_cnt_r_q <= clip_cnt_r_d;
      st2_valid_q  <= st2_valid_d;
      clip_left_q  <= clip_left_d;
      clip_right_q <= clip_right_d;
    end
  end

  assign bus.clip_left  = clip_left_q;
  assign bus.clip_right = clip_right_q;
`else
  assign bus.clip_left  = 1'b0;
  assign bus.clip_right = 1'b0;
`endif

endmodule
